dual_issue_scheduler: RTL

- Sits between the 2-wide fetch stage (PC advancing by 8, two 32-bit instructions per cycle) and the decode/issue backend.
- Each cycle it decides whether the fetched pair can issue together.
- On a hazard it issues slot 0 first, then the held slot 1 on the next cycle, stalling fetch in between.
- It also honours backend backpressure, drops work on branch flush, and counts split events.

---
 rtl/dual_issue_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler between the 2-wide fetch stage and the decode/issue backend.
// Each fetched pair either issues together or is split over two cycles.
// A pair is split when slot 1 depends on slot 0, when both access memory, or when
// slot 0 is a control transfer. Backend backpressure, branch flushes and a
// split-event counter are handled here as well.
module dual_issue_scheduler #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [ILEN-1:0] fetch_instr1,
  input  logic [ILEN-1:0] fetch_instr2,
  input  logic            flush,
  input  logic            issue_ready,
  output logic            fetch_stall,
  output logic            issue0_valid,
  output logic            issue1_valid,
  output logic [ILEN-1:0] issue0_instr,
  output logic [ILEN-1:0] issue1_instr,
  output logic [XLEN-1:0] issue0_pc,
  output logic [XLEN-1:0] issue1_pc,
  output logic [31:0]     split_count
);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  typedef enum logic {NORMAL, SECOND} state_t;

  state_t          state;
  logic [ILEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic [6:0] op1, op2;
  logic [4:0] rd1, rd2, rs1_2, rs2_2;
  logic       bubble1, bubble2;
  logic       raw_hazard, waw_hazard, mem_hazard, ctrl_hazard;
  logic       need_split;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OPC_OP) || (op == OPC_OP_IMM) || (op == OPC_LOAD) ||
           (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) ||
           (op == OPC_JALR) || (op == OPC_OP_32) || (op == OPC_OP_IMM_32);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !((op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL));
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OPC_OP) || (op == OPC_OP_32) || (op == OPC_STORE) || (op == OPC_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

  // Decode both fetched slots and decide whether the pair has to be split.
  always_comb begin
    op1         = fetch_instr1[6:0];
    op2         = fetch_instr2[6:0];
    rd1         = fetch_instr1[11:7];
    rd2         = fetch_instr2[11:7];
    rs1_2       = fetch_instr2[19:15];
    rs2_2       = fetch_instr2[24:20];
    bubble1     = (fetch_instr1 == '0);
    bubble2     = (fetch_instr2 == '0);
    raw_hazard  = writes_rd(op1) && (rd1 != 5'd0) &&
                  ((reads_rs1(op2) && (rs1_2 == rd1)) || (reads_rs2(op2) && (rs2_2 == rd1)));
    waw_hazard  = writes_rd(op1) && writes_rd(op2) && (rd1 != 5'd0) && (rd2 == rd1);
    mem_hazard  = is_mem(op1) && is_mem(op2);
    ctrl_hazard = is_ctrl(op1);
    need_split  = !bubble1 && !bubble2 &&
                  (raw_hazard || waw_hazard || mem_hazard || ctrl_hazard);
  end

  // Fetch holds its PC on backpressure or while the first half of a split issues;
  // a flush redirects fetch, so it never stalls in that cycle.
  always_comb begin
    fetch_stall = 1'b0;
    if (!reset_n) begin
      fetch_stall = 1'b0;
    end else if (flush) begin
      fetch_stall = 1'b0;
    end else if (!issue_ready) begin
      fetch_stall = 1'b1;
    end else if ((state == NORMAL) && fetch_valid && need_split) begin
      fetch_stall = 1'b1;
    end
  end

  // Issue FSM: pair or split issue, hold-register management and split counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= NORMAL;
      hold_instr   <= '0;
      hold_pc      <= '0;
      issue0_valid <= 1'b0;
      issue1_valid <= 1'b0;
      issue0_instr <= '0;
      issue1_instr <= '0;
      issue0_pc    <= '0;
      issue1_pc    <= '0;
      split_count  <= '0;
    end else if (flush) begin
      state        <= NORMAL;
      hold_instr   <= '0;
      hold_pc      <= '0;
      issue0_valid <= 1'b0;
      issue1_valid <= 1'b0;
    end else if (issue_ready) begin
      if (state == SECOND) begin
        issue0_valid <= 1'b1;
        issue0_instr <= hold_instr;
        issue0_pc    <= hold_pc;
        issue1_valid <= 1'b0;
        state        <= NORMAL;
      end else if (fetch_valid) begin
        issue0_valid <= !bubble1;
        issue0_instr <= fetch_instr1;
        issue0_pc    <= fetch_pc;
        if (need_split) begin
          issue1_valid <= 1'b0;
          hold_instr   <= fetch_instr2;
          hold_pc      <= fetch_pc + XLEN'(4);
          split_count  <= split_count + 32'd1;
          state        <= SECOND;
        end else begin
          issue1_valid <= !bubble2;
          issue1_instr <= fetch_instr2;
          issue1_pc    <= fetch_pc + XLEN'(4);
        end
      end else begin
        issue0_valid <= 1'b0;
        issue1_valid <= 1'b0;
      end
    end
  end

endmodule
